rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Boot-time program loader upstream of riscv_core. Accepts a byte stream (valid/ready),
//  assembles 32-bit instruction words and writes them into the instruction ROM.
//  Holds the core in reset until a complete image has been written.
//  Lets new programs be loaded without re-synthesising the ROM init file.
// PARAMETERS
//  ROM_DEPTH       4096     instruction words the ROM holds; larger images are rejected
//  BASE_ADDR       64'h0    byte address of word 0 (matches pc reset value)
//  TIMEOUT_CYCLES  1000000  max idle cycles between bytes once a load has started
// PORTS
//  clk            in   1                single clock
//  rst_n          in   1                asynchronous, active-low reset
//  load_start_i   in   1                1-cycle pulse: begin a (re)load
//  byte_valid_i   in   1                byte_data_i holds a valid byte
//  byte_data_i    in   8                stream byte
//  byte_ready_o   out  1                loader accepts a byte this cycle
//  rom_wr_en_o    out  1                1-cycle ROM write strobe
//  rom_wr_addr_o  out  `ADDR_BUS_WIDTH  byte address = BASE_ADDR + 4*word_index
//  rom_wr_data_o  out  `INST_WIDTH      assembled word
//  core_rst_n_o   out  1                active-low reset to riscv_core
//  load_done_o    out  1                image loaded, core released
//  load_err_o     out  1                last load failed (oversize or timeout)
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready_o=0, rom_wr_en_o=0, rom_wr_addr_o=BASE_ADDR,
//   rom_wr_data_o=0, core_rst_n_o=0, load_done_o=0, load_err_o=0; all counters 0.
//  A byte is accepted only on a cycle where byte_valid_i && byte_ready_o.
//  byte_ready_o=1 only in LEN and DATA; all other states drop bytes (ready=0).
//  Stream format: 2-byte word count N (LSB first), then 4*N image bytes.
//  Byte order: the 1st byte of each word goes to [31:24], the 4th to [7:0]. The ROM
//   stores raw stream order; the fetch path's endian swap is not duplicated here.
//  States:
//   IDLE : load_start_i -> LEN. core_rst_n_o stays 0.
//   LEN  : accept 2 bytes into N. After the 2nd byte: N==0 -> DONE;
//          N>ROM_DEPTH -> ERROR; otherwise -> DATA.
//   DATA : shift bytes into a 32-bit assembly register. On the 4th byte of a word,
//          the next cycle drives rom_wr_en_o=1 for exactly one cycle with data and
//          address, then word_index++. Byte acceptance continues that cycle
//          (no bubble). After word N-1 is written -> DONE.
//   DONE : core_rst_n_o=1, load_done_o=1, load_err_o=0. load_start_i -> LEN,
//          with core_rst_n_o=0 and load_done_o=0 from the next cycle (core held during reload).
//   ERROR: load_err_o=1, core_rst_n_o=0. load_start_i -> LEN and clears load_err_o.
//  Timeout: in LEN/DATA a counter increments every cycle without an accepted byte and
//   clears on every accepted byte. Reaching TIMEOUT_CYCLES -> ERROR. Partial word discarded.
//  load_start_i in LEN/DATA restarts the load: counters and assembly register cleared,
//   state=LEN. A byte accepted in that same cycle is discarded.
//  rom_wr_en_o is never asserted outside DATA->write cycles. The address never exceeds
//   BASE_ADDR+4*(ROM_DEPTH-1).
//  Async reset mid-load returns to the IDLE values above immediately. The ROM contents
//   are then undefined, and the core stays in reset.
//  Latency: final ROM write 1 cycle after the last byte; core_rst_n_o rises 1 cycle after that write.
// STRUCTURE
//  Shared package/defines: state encoding localparams (LDR_IDLE/LEN/DATA/DONE/ERROR).
//   ADDR_BUS_WIDTH and INST_WIDTH come from defines.v.
//  Single module, no sub-modules. FSM, byte counter (2b), word counter, timeout counter.
//  The top level gains a wrapper: riscv_core rst_n <= core_rst_n_o, and the ROM gets a write port.
// TESTING
//  1 Load N=2, bytes 02 00 | 13 05 10 00 | 93 05 20 00 -> writes {addr 0, 32'h13051000},
//    {addr 4, 32'h93052000}; core_rst_n_o rises 1 cycle after 2nd write; load_done_o=1.
//  2 N=0 (00 00) -> DONE with no rom_wr_en_o pulse; core released.
//  3 N=ROM_DEPTH+1 -> ERROR after 2nd length byte; load_err_o=1, no writes, core held.
//  4 TIMEOUT_CYCLES=16: send 02 00 13 05 then stall -> ERROR on cycle 16; a later
//    load_start_i plus a good image -> DONE and load_err_o cleared.
//  5 Random byte_valid_i gaps (<timeout) over a 64-word image -> every ROM word matches
//    the scoreboard; rom_wr_en_o is never high 2 cycles in a row.
//  6 load_start_i in DONE, then reload -> core_rst_n_o low for the whole reload.
//    rst_n pulse mid-DATA -> all outputs take reset values asynchronously.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared widths and loader state encoding
package rom_loader_pkg;

  localparam int ADDR_BUS_WIDTH = 64;
  localparam int INST_WIDTH     = 32;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LEN,
    LDR_DATA,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_e;

endpackage

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot loader: byte stream -> instruction ROM words, holds core in reset until loaded
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned               ROM_DEPTH      = 4096,
  parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned               TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_data_i,
  output logic                      byte_ready_o,
  output logic                      rom_wr_en_o,
  output logic [ADDR_BUS_WIDTH-1:0] rom_wr_addr_o,
  output logic [INST_WIDTH-1:0]     rom_wr_data_o,
  output logic                      core_rst_n_o,
  output logic                      load_done_o,
  output logic                      load_err_o
);

  ldr_state_e            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [31:0]           to_q, to_d;
  logic [23:0]           asm_q, asm_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [INST_WIDTH-1:0] wr_data_q, wr_data_d;

  logic        accept;
  logic        last_word;
  logic        timeout_hit;
  logic [15:0] len_full;

  assign last_word   = (word_idx_q == len_q - 16'd1);
  assign timeout_hit = (to_q == TIMEOUT_CYCLES - 32'd1);
  assign len_full    = {byte_data_i, len_q[7:0]};

  // Stop taking bytes once the final word is assembled and only its write remains.
  assign byte_ready_o = (state_q == LDR_LEN) ||
                        ((state_q == LDR_DATA) && !(wr_pend_q && last_word));
  assign accept       = byte_valid_i && byte_ready_o;

  assign rom_wr_en_o   = wr_pend_q;
  assign rom_wr_addr_o = BASE_ADDR + ADDR_BUS_WIDTH'({word_idx_q, 2'b00});
  assign rom_wr_data_o = wr_data_q;
  assign core_rst_n_o  = (state_q == LDR_DONE);
  assign load_done_o   = (state_q == LDR_DONE);
  assign load_err_o    = (state_q == LDR_ERROR);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    to_d       = to_q;
    asm_d      = asm_q;
    wr_pend_d  = 1'b0;
    wr_data_d  = wr_data_q;

    if (load_start_i) begin
      state_d    = LDR_LEN;
      byte_cnt_d = 2'd0;
      len_d      = 16'd0;
      word_idx_d = 16'd0;
      to_d       = 32'd0;
      asm_d      = 24'd0;
    end else begin
      case (state_q)
        LDR_LEN: begin
          if (accept) begin
            to_d = 32'd0;
            if (byte_cnt_q == 2'd0) begin
              len_d[7:0] = byte_data_i;
              byte_cnt_d = 2'd1;
            end else begin
              len_d      = len_full;
              byte_cnt_d = 2'd0;
              if (len_full == 16'd0)                   state_d = LDR_DONE;
              else if ({16'd0, len_full} > ROM_DEPTH)  state_d = LDR_ERROR;
              else                                     state_d = LDR_DATA;
            end
          end else if (timeout_hit) begin
            state_d = LDR_ERROR;
          end else begin
            to_d = to_q + 32'd1;
          end
        end
        LDR_DATA: begin
          if (wr_pend_q) begin
            word_idx_d = word_idx_q + 16'd1;
            if (last_word) state_d = LDR_DONE;
          end
          if (accept) begin
            to_d       = 32'd0;
            asm_d      = {asm_q[15:0], byte_data_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_pend_d = 1'b1;
              wr_data_d = {asm_q, byte_data_i};
            end
          end else if (!(wr_pend_q && last_word)) begin
            if (timeout_hit) state_d = LDR_ERROR;
            else             to_d    = to_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LDR_IDLE;
      byte_cnt_q <= 2'd0;
      len_q      <= 16'd0;
      word_idx_q <= 16'd0;
      to_q       <= 32'd0;
      asm_q      <= 24'd0;
      wr_pend_q  <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      to_q       <= to_d;
      asm_q      <= asm_d;
      wr_pend_q  <= wr_pend_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader with randomized byte gaps
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int unsigned TO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o;
  logic        rom_wr_en_o;
  logic [63:0] rom_wr_addr_o;
  logic [31:0] rom_wr_data_o;
  logic        core_rst_n_o;
  logic        load_done_o;
  logic        load_err_o;

  rom_loader #(.ROM_DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .rom_wr_en_o(rom_wr_en_o), .rom_wr_addr_o(rom_wr_addr_o), .rom_wr_data_o(rom_wr_data_o),
    .core_rst_n_o(core_rst_n_o), .load_done_o(load_done_o), .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] img_q[$];
  bit          prev_wr = 1'b0;
  bit          reload_watch = 1'b0;
  int          reload_rel = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ROM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0;
    end else begin
      if (rom_wr_en_o) begin
        check("wr_en_gap", {63'd0, prev_wr}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", rom_wr_addr_o, e.addr);
          check("wr_data", {32'd0, rom_wr_data_o}, {32'd0, e.data});
        end
      end
      prev_wr = rom_wr_en_o;
      if (reload_watch && core_rst_n_o && !load_done_o) reload_rel++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  n;
    bit  acc;
    repeat ($urandom_range(max_gap, 0)) tick();
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = byte_ready_o;
      tick();
      n++;
    end
    byte_valid_i = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  // Reference: word i lands at BASE+4*i, first stream byte in bits [31:24].
  task automatic load_image(input int max_gap);
    int          n;
    logic [31:0] w;
    wr_t         e;
    n = img_q.size();
    start_load();
    send_byte(n[7:0], max_gap);
    send_byte(n[15:8], max_gap);
    for (int i = 0; i < n; i++) begin
      w      = img_q[i];
      e.addr = BASE + 64'(4 * i);
      e.data = w;
      exp_q.push_back(e);
      send_byte(w[31:24], max_gap);
      send_byte(w[23:16], max_gap);
      send_byte(w[15:8], max_gap);
      send_byte(w[7:0], max_gap);
    end
    @(negedge clk);
    if (n > 0) begin
      check("last_write_latency", {63'd0, rom_wr_en_o}, 64'd1);
      check("core_held_during_last_write", {63'd0, core_rst_n_o}, 64'd0);
      @(negedge clk);
    end
    check("core_released", {63'd0, core_rst_n_o}, 64'd1);
    check("load_done", {63'd0, load_done_o}, 64'd1);
    check("load_err_clear", {63'd0, load_err_o}, 64'd0);
    check("no_pending_writes", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd0);
    check({tag, "_wr_en"}, {63'd0, rom_wr_en_o}, 64'd0);
    check({tag, "_addr"}, rom_wr_addr_o, BASE);
    check({tag, "_data"}, {32'd0, rom_wr_data_o}, 64'd0);
    check({tag, "_core_rst_n"}, {63'd0, core_rst_n_o}, 64'd0);
    check({tag, "_done"}, {63'd0, load_done_o}, 64'd0);
    check({tag, "_err"}, {63'd0, load_err_o}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    check("idle_ready", {63'd0, byte_ready_o}, 64'd0);

    // Fixed two-word image
    img_q = '{32'h13051000, 32'h93052000};
    load_image(0);

    // Empty image
    img_q = '{};
    load_image(2);

    // Oversize image: N = DEPTH+1
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    @(negedge clk);
    check("oversize_err", {63'd0, load_err_o}, 64'd1);
    check("oversize_core_held", {63'd0, core_rst_n_o}, 64'd0);
    check("oversize_ready", {63'd0, byte_ready_o}, 64'd0);
    repeat (4) tick();
    check("oversize_err_sticky", {63'd0, load_err_o}, 64'd1);

    // Timeout after a partial word, then recovery
    start_load();
    @(negedge clk);
    check("restart_clears_err", {63'd0, load_err_o}, 64'd0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("timeout_not_early", {63'd0, load_err_o}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("timeout_err", {63'd0, load_err_o}, 64'd1);
    check("timeout_core_held", {63'd0, core_rst_n_o}, 64'd0);
    tick();
    img_q = '{$urandom, $urandom};
    load_image(3);

    // 64-word random image with random gaps
    img_q = '{};
    for (int i = 0; i < 64; i++) img_q.push_back($urandom);
    load_image(6);

    // Reload from DONE keeps the core in reset
    load_start_i = 1'b1;
    @(posedge clk);
    #1;
    load_start_i = 1'b0;
    @(negedge clk);
    check("reload_core_held", {63'd0, core_rst_n_o}, 64'd0);
    check("reload_done_low", {63'd0, load_done_o}, 64'd0);
    reload_watch = 1'b1;
    img_q = '{};
    for (int i = 0; i < 8; i++) img_q.push_back($urandom);
    load_image(4);
    reload_watch = 1'b0;
    check("reload_core_never_released", 64'(reload_rel), 64'd0);

    // Async reset mid-DATA
    begin
      logic [31:0] w;
      wr_t         e;
      w = $urandom;
      start_load();
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      e.addr = BASE;
      e.data = w;
      exp_q.push_back(e);
      send_byte(w[31:24], 1);
      send_byte(w[23:16], 1);
      send_byte(w[15:8], 1);
      send_byte(w[7:0], 1);
      send_byte(8'hAA, 1);
      send_byte(8'h55, 1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      #3;
      rst_n = 1'b1;
      check("reset_writes_drained", 64'(exp_q.size()), 64'd0);
      tick();
      tick();
      check("post_reset_idle_ready", {63'd0, byte_ready_o}, 64'd0);
      check("post_reset_core_held", {63'd0, core_rst_n_o}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
